key_events: RTL
===============

# key_events

Converts the debounced button levels into a stream of discrete key events for the CPU-side keyboard register. Each press or release produces one event. The most recently pressed key auto-repeats. Events are queued in a small first-word-fall-through FIFO behind a valid/ready handshake. The block sits directly downstream of the per-button debouncers and upstream of the bus-visible keyboard data/status registers.

## Interface
Parameters:
- N, 4: number of buttons, 1..64.
- TICK_DIV, 50000: clk cycles per tick (1 ms at 50 MHz), ≥2.
- REPEAT_DELAY, 500: ticks from press to first repeat, ≥1.
- REPEAT_PERIOD, 100: ticks between subsequent repeats, ≥1.
- FIFO_DEPTH, 4: event queue depth, power of two, ≥2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn  in  N  debounced button levels, 1 = pressed; asynchronous to clk.
- ev_valid  out  1  FIFO head holds an event.
- ev_code  out  8  head event: [7] = 1 press / 0 release, [6] = repeat, [5:0] = button index.
- ev_ready  in  1  consumer accepts the head when ev_valid is high.
- ev_count  out  log2(FIFO_DEPTH)+1  number of queued events.
- overflow  out  1  sticky flag: a repeat event was lost.
- ovf_clr  in  1  clears overflow.

## Operation
- Synchroniser: btn passes through two flops per bit, giving `bs`.
- Event source:
  - `rep[N-1:0]` holds the last reported state of each button.
  - Each cycle, the lowest index i with `bs[i] != rep[i]` is selected.
  - The event {bs[i], 0, i} is pushed only if the FIFO can accept it; in that case `rep[i] <= bs[i]`.
  - Otherwise nothing changes, so edges are deferred, never lost.
  - Only one edge event is pushed per cycle.
- Tick prescaler: counts 0..TICK_DIV-1 and emits a 1-cycle `tick` at wrap.
- Auto-repeat state: `r_act`, `r_key`, `r_cnt`, `r_pend`.
  - When a press of key i is pushed: r_act=1, r_key=i, r_cnt=REPEAT_DELAY, r_pend=0.
  - When a release of r_key is pushed: r_act=0, r_pend=0.
  - When a release of any other key is pushed: no change.
  - On tick with r_act: if r_cnt==1, then r_cnt=REPEAT_PERIOD and r_pend=1; else r_cnt decrements.
  - Coalescing: if r_pend is already 1 at expiry, overflow <= 1 and the repeat is coalesced.
  - r_pend pushes {1, 1, r_key} only in a cycle with no selected edge event and FIFO room; r_pend then clears.
- FIFO:
  - First-word-fall-through: ev_code is valid whenever ev_valid=1.
  - Pop on ev_valid && ev_ready.
  - "Can accept" means count < FIFO_DEPTH, or a pop occurs in the same cycle.
  - Simultaneous push and pop at any level leaves count unchanged.
- Overflow: set by a coalesced repeat. ovf_clr clears it. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values (asynchronous, immediate):
  - Outputs: ev_valid=0, ev_code=0, ev_count=0, overflow=0.
  - Internal: rep=0, r_act=0, r_pend=0, prescaler=0, synchroniser=0.
- Buttons held through reset produce press events after reset.
- Latency: btn changes before edge 0, is in `bs` after edge 1, and is pushed at edge 2. ev_valid is high after edge 2 when the FIFO was empty.
- Pop then refill: ev_count and ev_valid update on the edge of the pop.
- A held key's first repeat is pushed on the cycle after the REPEAT_DELAY-th tick following its press push. Each subsequent repeat follows REPEAT_PERIOD ticks later, given no contention.
- Press of a second key while the first is held: repeat transfers to the new key and r_cnt reloads with REPEAT_DELAY.
- FIFO full with ev_ready=0: edge events stall in `rep`. Once space frees, they drain at one per cycle, lowest index first.
- Reset mid-operation discards queued events and repeat state.

## Test plan
- After reset, btn=4'b0000 → 4'b0100 with ev_ready=1 → ev_valid rises after the 2nd edge, ev_code=8'h82, ev_count=1, then 0 after the pop.
- btn 4'b0000 → 4'b1011 in one cycle, ev_ready=0 → codes 8'h80, 8'h81, 8'h83 queued on three consecutive cycles, ev_count=3.
- TICK_DIV=4, REPEAT_DELAY=3, REPEAT_PERIOD=2; hold btn[1] → press 8'h81, first repeat 8'hC1 12 cycles after the press push, then 8'hC1 every 8 cycles. Release → 8'h01 and no further repeats.
- Fill the FIFO (depth 4) with ev_ready=0, then toggle btn[0] → no push and ev_count stays 4. One pop → 8'h00 or 8'h80 pushed in the same cycle.
- Hold a key with the FIFO full past two repeat expiries → overflow=1. Pulse ovf_clr → overflow=0. Assert ovf_clr on the expiry cycle → overflow stays 1.
- Assert reset with ev_count=3 and r_act=1 → all outputs are 0 immediately. After release, held buttons re-report presses.

Source files
------------

// File: rtl/key_events.sv
// key_events: turns synchronised button levels into press/release/auto-repeat
// key events, queued in a first-word-fall-through FIFO with valid/ready output.
module key_events #(
    parameter int N             = 4,
    parameter int TICK_DIV      = 50000,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N-1:0]                  btn,
    output logic                          ev_valid,
    output logic [7:0]                    ev_code,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          overflow,
    input  logic                          ovf_clr
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int PW   = $clog2(TICK_DIV);
    localparam int IW   = N > 1 ? $clog2(N) : 1;
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(RMAX + 1);

    logic [N-1:0]    s1_q, bs_q, rep_q, rep_d;
    logic [PW-1:0]   pc_q;
    logic            r_act_q, r_act_d, r_pend_q, r_pend_d, ovf_q, ovf_d;
    logic [5:0]      r_key_q, r_key_d;
    logic [CW-1:0]   r_cnt_q, r_cnt_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CNTW-1:0] cnt_q;
    logic            tick, pop, room, sel_v, sel_b, edge_push, rep_push, push;
    logic [IW-1:0]   sel_i;
    logic [7:0]      push_code;

    assign tick      = pc_q == PW'(TICK_DIV - 1);
    assign ev_valid  = cnt_q != '0;
    assign ev_code   = ev_valid ? mem_q[rd_q] : 8'h00;
    assign ev_count  = cnt_q;
    assign overflow  = ovf_q;
    assign pop       = ev_valid && ev_ready;
    assign room      = 32'(cnt_q) < FIFO_DEPTH || pop;
    assign sel_b     = bs_q[sel_i];
    assign edge_push = sel_v && room;
    assign rep_push  = !sel_v && r_pend_q && room;
    assign push      = edge_push || rep_push;
    assign push_code = sel_v ? {sel_b, 1'b0, 6'(sel_i)} : {2'b11, r_key_q};

    // Downward scan so the lowest differing index is the one left selected.
    always_comb begin
        sel_v = 1'b0;
        sel_i = '0;
        for (int i = N - 1; i >= 0; i--)
            if (bs_q[i] != rep_q[i]) begin
                sel_v = 1'b1;
                sel_i = IW'(i);
            end
    end

    always_comb begin
        rep_d    = rep_q;
        r_act_d  = r_act_q;
        r_key_d  = r_key_q;
        r_cnt_d  = r_cnt_q;
        r_pend_d = rep_push ? 1'b0 : r_pend_q;
        ovf_d    = ovf_q && !ovf_clr;
        if (edge_push)
            rep_d[sel_i] = sel_b;
        if (edge_push && sel_b) begin
            r_act_d  = 1'b1;
            r_key_d  = 6'(sel_i);
            r_cnt_d  = CW'(REPEAT_DELAY);
            r_pend_d = 1'b0;
        end else if (edge_push && 6'(sel_i) == r_key_q) begin
            r_act_d  = 1'b0;
            r_pend_d = 1'b0;
        end else if (tick && r_act_q) begin
            // A repeat still pending at expiry (and not leaving this cycle) is coalesced.
            r_cnt_d  = r_cnt_q == CW'(1) ? CW'(REPEAT_PERIOD) : r_cnt_q - 1'b1;
            r_pend_d = r_cnt_q == CW'(1) ? 1'b1 : r_pend_d;
            ovf_d    = ovf_d || (r_cnt_q == CW'(1) && r_pend_q && !rep_push);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= '0;
            bs_q     <= '0;
            rep_q    <= '0;
            pc_q     <= '0;
            r_act_q  <= 1'b0;
            r_key_q  <= '0;
            r_cnt_q  <= '0;
            r_pend_q <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            s1_q     <= btn;
            bs_q     <= s1_q;
            rep_q    <= rep_d;
            pc_q     <= tick ? '0 : pc_q + 1'b1;
            r_act_q  <= r_act_d;
            r_key_q  <= r_key_d;
            r_cnt_q  <= r_cnt_d;
            r_pend_q <= r_pend_d;
            ovf_q    <= ovf_d;
            if (push) begin
                mem_q[wr_q] <= push_code;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
        end
    end
endmodule
